// File: rtl/xtea_engine_if.sv
// XTEA engine control/data bundle: request side drives start/mode/abort/v/k, engine returns busy/done/data_o.
// Latency: none (wires only).
// Backpressure: none; the requester must hold off while busy, since start is only sampled when the engine is idle.
// Ports: start, mode (0 enc / 1 dec), abort, v (64*LANES), k (128) -> engine; busy, done, data_o (64*LANES) <- engine.
interface xtea_engine_if #(
  parameter int LANES = 2
);
  logic                  start;
  logic                  mode;
  logic                  abort;
  logic [64*LANES-1:0]   v;
  logic [127:0]          k;
  logic                  busy;
  logic                  done;
  logic [64*LANES-1:0]   data_o;

  modport master (
    output start, mode, abort, v, k,
    input  busy, done, data_o
  );

  modport slave (
    input  start, mode, abort, v, k,
    output busy, done, data_o
  );
endinterface

// File: rtl/xtea_engine.sv
// XTEA block cipher engine: LANES 64-bit blocks encrypted/decrypted in parallel with a shared key and sum.
// Latency: 3*ROUNDS+1 cycles from the start edge to the edge that raises done (one-cycle pulse).
// Backpressure: start is ignored while busy; abort cancels a running operation, leaving data_o and done untouched.
// Ports: clock, reset_n (async active-low), bus (xtea_engine_if.slave: start/mode/abort/v/k in, busy/done/data_o out).
module xtea_engine #(
  parameter int          LANES  = 2,
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic            clock,
  input  logic            reset_n,
  xtea_engine_if.slave    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RND_A  = 3'd1;
  localparam logic [2:0] S_RND_S  = 3'd2;
  localparam logic [2:0] S_RND_B  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [5:0]  L_ROUNDS  = 6'(ROUNDS);
  // Decrypt walks the schedule backwards, so it starts from the sum encrypt ends on.
  localparam logic [63:0] L_PROD    = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] L_DEC_SUM = L_PROD[31:0];

  logic [2:0]                r_state;
  logic                      r_mode;
  logic [31:0]               r_sum;
  logic [5:0]                r_cnt;
  logic [3:0][31:0]          r_key;
  logic [LANES-1:0][31:0]    r_y;
  logic [LANES-1:0][31:0]    r_z;
  logic [64*LANES-1:0]       r_data_o;
  logic                      r_done;

  logic [31:0] w_ta;
  logic [31:0] w_tb;
  logic [5:0]  w_cnt_nxt;

  function automatic logic [31:0] f_mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  // Key-mixed sum terms, shared by every lane.
  assign w_ta      = r_sum + r_key[r_sum[1:0]];
  assign w_tb      = r_sum + r_key[r_sum[12:11]];
  assign w_cnt_nxt = r_cnt + 6'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_key    <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_data_o <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RND_A;
            r_mode  <= bus.mode;
            r_key   <= bus.k;
            r_cnt   <= '0;
            r_sum   <= bus.mode ? L_DEC_SUM : 32'd0;
            for (int j = 0; j < LANES; j++) begin
              r_y[j] <= bus.v[64*j +: 32];
              r_z[j] <= bus.v[64*j+32 +: 32];
            end
          end
        end
        S_RND_A: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            for (int j = 0; j < LANES; j++) begin
              if (!r_mode) r_y[j] <= r_y[j] + (f_mix(r_z[j]) ^ w_ta);
              else         r_z[j] <= r_z[j] - (f_mix(r_y[j]) ^ w_tb);
            end
            r_state <= S_RND_S;
          end
        end
        S_RND_S: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_sum   <= r_mode ? (r_sum - DELTA) : (r_sum + DELTA);
            r_state <= S_RND_B;
          end
        end
        S_RND_B: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            for (int j = 0; j < LANES; j++) begin
              if (!r_mode) r_z[j] <= r_z[j] + (f_mix(r_y[j]) ^ w_tb);
              else         r_y[j] <= r_y[j] - (f_mix(r_z[j]) ^ w_ta);
            end
            r_cnt   <= w_cnt_nxt;
            r_state <= (w_cnt_nxt < L_ROUNDS) ? S_RND_A : S_FINISH;
          end
        end
        S_FINISH: begin
          // abort is deliberately not looked at here: the result is already final.
          for (int j = 0; j < LANES; j++) begin
            r_data_o[64*j +: 64] <= {r_z[j], r_y[j]};
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.data_o = r_data_o;

endmodule

// File: tb/tb_xtea_engine.sv
// Self-checking bench for xtea_engine: a 2-lane/32-round instance and a 1-lane/1-round instance.
// Latency: expectations carry the start cycle so each done is checked for data and cycle count.
// Backpressure: stimulus waits for idle (bounded) before each new start.
module tb_xtea_engine;

  localparam logic [31:0] D = 32'h9E3779B9;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  xtea_engine_if #(.LANES(2)) bus ();
  xtea_engine_if #(.LANES(1)) sbus ();

  xtea_engine #(.LANES(2), .ROUNDS(32), .DELTA(D)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  xtea_engine #(.LANES(1), .ROUNDS(1), .DELTA(D)) u_small (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_s[$];
  exp_t e_m;
  exp_t e_s;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kw(input logic [127:0] key, input logic [1:0] idx);
    return key[32*idx +: 32];
  endfunction

  // Reference XTEA encipher on one 64-bit block {z, y}.
  function automatic logic [63:0] xtea_enc(input logic [63:0] blk, input logic [127:0] key, input int rounds);
    logic [31:0] y, z, s;
    y = blk[31:0];
    z = blk[63:32];
    s = 32'd0;
    for (int r = 0; r < rounds; r++) begin
      y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw(key, s[1:0])));
      s = s + D;
      z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw(key, s[12:11])));
    end
    return {z, y};
  endfunction

  function automatic logic [127:0] enc2(input logic [127:0] vv, input logic [127:0] kk);
    return {xtea_enc(vv[127:64], kk, 32), xtea_enc(vv[63:0], kk, 32)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard monitors: every done pops one expectation.
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 128'(bus.done), 128'd0);
      end else begin
        e_m = sb_q.pop_front();
        check_val("data", bus.data_o, e_m.data);
        check_val("latency", 128'(cyc - e_m.t0), 128'd97);
      end
    end
  end

  always @(negedge clock) begin
    if (sbus.done === 1'b1) begin
      if (sb_s.size() == 0) begin
        check_val("s_spurious_done", 128'(sbus.done), 128'd0);
      end else begin
        e_s = sb_s.pop_front();
        check_val("s_data", {64'd0, sbus.data_o}, e_s.data);
        check_val("s_latency", 128'(cyc - e_s.t0), 128'd4);
      end
    end
  end

  task automatic kick(input logic m, input logic [127:0] vv, input logic [127:0] kk,
                      input bit ab, input bit push, input logic [127:0] expv);
    exp_t e;
    @(negedge clock);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.v     = vv;
    bus.k     = kk;
    bus.abort = ab;
    if (push) begin
      e.data = expv;
      e.t0   = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic kick_s(input logic m, input logic [63:0] vv, input logic [127:0] kk, input logic [127:0] expv);
    exp_t e;
    @(negedge clock);
    sbus.start = 1'b1;
    sbus.mode  = m;
    sbus.v     = vv;
    sbus.k     = kk;
    e.data = expv;
    e.t0   = cyc + 1;
    sb_s.push_back(e);
    @(negedge clock);
    sbus.start = 1'b0;
  endtask

  task automatic wait_main(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && bus.busy === 1'b0) break;
    end
    check_val("drain", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic wait_s(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sb_s.size() == 0 && sbus.busy === 1'b0) break;
    end
    check_val("s_drain", 128'(sb_s.size()), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] va, ka, ca, prev;
    exp_t e;
    int t_first;

    bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0; bus.v = '0; bus.k = '0;
    sbus.start = 1'b0; sbus.mode = 1'b0; sbus.abort = 1'b0; sbus.v = '0; sbus.k = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_busy", 128'(bus.busy), 128'd0);
    check_val("rst_done", 128'(bus.done), 128'd0);
    check_val("rst_data", bus.data_o, 128'd0);
    check_val("rst_s_data", {64'd0, sbus.data_o}, 128'd0);
    reset_n = 1'b1;

    // Single round known answers, encrypt then decrypt.
    kick_s(1'b0, 64'h0, 128'h0, {64'h0, 64'h9E3779B9_00000000});
    wait_s(20);
    kick_s(1'b1, 64'h9E3779B9_00000000, 128'h0, 128'h0);
    wait_s(20);

    // Full-round roundtrips; inputs scrambled mid-operation must not matter.
    for (int t = 0; t < 3; t++) begin
      va = rnd128();
      ka = rnd128();
      ca = enc2(va, ka);
      kick(1'b0, va, ka, 1'b0, 1'b1, ca);
      @(negedge clock);
      bus.v = rnd128(); bus.k = rnd128(); bus.mode = 1'b1;
      wait_main(200);
      check_val("enc_hold", bus.data_o, ca);
      kick(1'b1, ca, ka, 1'b0, 1'b1, va);
      @(negedge clock);
      bus.v = rnd128(); bus.k = rnd128(); bus.mode = 1'b0;
      wait_main(200);
    end

    // Lane independence: zero block on lane 0 next to random lane 1.
    va = {rnd128() >> 64};
    va = {va[63:0], 64'h0};
    ka = rnd128();
    ca = enc2(va, ka);
    kick(1'b0, va, ka, 1'b0, 1'b1, ca);
    wait_main(200);
    check_val("lane0_indep", {64'd0, bus.data_o[63:0]}, {64'd0, xtea_enc(64'h0, ka, 32)});

    // Abort around round 10: no done, output untouched.
    prev = bus.data_o;
    kick(1'b0, rnd128(), rnd128(), 1'b0, 1'b0, 128'h0);
    repeat (28) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check_val("abort_busy", 128'(bus.busy), 128'd0);
    check_val("abort_hold", bus.data_o, prev);

    // New operation started with abort also high in idle.
    va = rnd128();
    ka = rnd128();
    ca = enc2(va, ka);
    kick(1'b0, va, ka, 1'b1, 1'b1, ca);
    repeat (40) @(negedge clock);
    check_val("mid_busy", 128'(bus.busy), 128'd1);
    check_val("mid_hold", bus.data_o, prev);
    wait_main(200);

    // start pulsed while busy is ignored.
    va = rnd128();
    ka = rnd128();
    ca = enc2(va, ka);
    kick(1'b0, va, ka, 1'b0, 1'b1, ca);
    repeat (20) @(negedge clock);
    bus.start = 1'b1;
    bus.v = rnd128();
    @(negedge clock);
    bus.start = 1'b0;
    wait_main(200);
    repeat (120) @(negedge clock);
    check_val("busy_start_ignored", 128'(bus.busy), 128'd0);
    check_val("busy_start_data", bus.data_o, ca);

    // start held high: back-to-back operations with one idle cycle between.
    va = rnd128();
    ka = rnd128();
    ca = enc2(va, ka);
    @(negedge clock);
    bus.start = 1'b1; bus.mode = 1'b0; bus.v = va; bus.k = ka;
    t_first = cyc + 1;
    e.data = ca; e.t0 = t_first;      sb_q.push_back(e);
    e.data = ca; e.t0 = t_first + 98; sb_q.push_back(e);
    for (int i = 0; i < 200; i++) begin
      if (cyc >= t_first + 98) break;
      @(negedge clock);
    end
    bus.start = 1'b0;
    wait_main(300);

    // Reset while in RND_S.
    kick(1'b0, rnd128(), rnd128(), 1'b0, 1'b0, 128'h0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("arst_busy", 128'(bus.busy), 128'd0);
    check_val("arst_done", 128'(bus.done), 128'd0);
    check_val("arst_data", bus.data_o, 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // First operation after reset behaves as from power-up.
    va = rnd128();
    ka = rnd128();
    ca = enc2(va, ka);
    kick(1'b0, va, ka, 1'b0, 1'b1, ca);
    wait_main(200);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
